// File: rtl/sdram_arb_pkg.sv
// ----------------------------------------------------------------------------
// sdram_arb_pkg
// Shared types and constants for the SDRAM host-port arbiter.
//   ARB_MAX_PORTS : largest supported requester count
//   ARB_IDX_W     : width of a port index (enough for ARB_MAX_PORTS)
//   ARB_TMR_W     : width of the ISSUE/BUSY timeout counter
//   arb_state_e   : arbiter FSM state encoding
// ----------------------------------------------------------------------------
package sdram_arb_pkg;

    localparam int ARB_MAX_PORTS = 8;
    localparam int ARB_IDX_W     = 3;
    localparam int ARB_TMR_W     = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GRANT = 3'd1,
        ST_ISSUE = 3'd2,
        ST_BUSY  = 3'd3,
        ST_DONE  = 3'd4
    } arb_state_e;

endpackage

// File: rtl/sdram_rr_picker.sv
// ----------------------------------------------------------------------------
// sdram_rr_picker
// Combinational round-robin winner selection.
//   valid     in  : per-port request vector
//   last_idx  in  : index granted most recently; search starts one above it
//   prio0_en  in  : port 0 wins outright whenever it is valid; the remaining
//                   ports rotate among themselves
//   win_idx   out : selected port (0 when nothing is valid)
//   any_valid out : at least one port is requesting
// ----------------------------------------------------------------------------
module sdram_rr_picker
    import sdram_arb_pkg::*;
#(
    parameter int NUM_PORTS = 2
) (
    input  logic [NUM_PORTS-1:0] valid,
    input  logic [ARB_IDX_W-1:0] last_idx,
    input  logic                 prio0_en,
    output logic [ARB_IDX_W-1:0] win_idx,
    output logic                 any_valid
);

    logic [ARB_MAX_PORTS-1:0] valid_ext_s;

    assign valid_ext_s = ARB_MAX_PORTS'(valid);

    // Scan upward from last_idx+1 with wrap; first eligible requester wins.
    always_comb begin
        logic [ARB_IDX_W-1:0] cand;
        logic                 found;
        cand      = '0;
        found     = 1'b0;
        win_idx   = '0;
        any_valid = |valid;
        if (prio0_en && valid_ext_s[0]) begin
            win_idx = '0;
            found   = 1'b1;
        end else begin
            for (int off = 1; off <= NUM_PORTS; off++) begin
                cand = ARB_IDX_W'((int'(last_idx) + off) % NUM_PORTS);
                // With priority enabled port 0 is handled above, so skip it here.
                if (!found && valid_ext_s[cand] && !(prio0_en && (cand == '0))) begin
                    win_idx = cand;
                    found   = 1'b1;
                end else begin
                    found = found;
                end
            end
        end
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// ----------------------------------------------------------------------------
// sdram_port_arbiter
// Shares the single-command SDRAM controller host interface among NUM_PORTS
// requesters. One op at a time: pick (IDLE), accept (GRANT), hold the enable
// until the controller goes busy (ISSUE), wait for busy to fall (BUSY), then
// report completion (DONE). ISSUE and BUSY are bounded by TIMEOUT_CYC cycles,
// after which the op is aborted and completed with rsp_err=1.
//
// Build option: define SDRAM_ARB_PRIO0_EN to give port 0 absolute priority;
// otherwise all ports share pure round-robin.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   req_valid/we/addr/wdata  per-port request payload (held until req_ready)
//   req_ready             one-hot accept pulse (high during GRANT)
//   rsp_valid             one-hot completion pulse (high during DONE)
//   rsp_err               completion was a timeout abort
//   rsp_rdata             read data of the last completed read
//   mc_wr_addr/mc_rd_addr latched op address to the controller
//   mc_wr_data            latched write data
//   mc_wr_enable/mc_rd_enable  controller command enables (high in ISSUE)
//   mc_rd_data/mc_rd_ready     controller read return
//   mc_busy               controller busy
// ----------------------------------------------------------------------------
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int NUM_PORTS   = 2,
    parameter int HADDR_WIDTH = 24,
    parameter int DATA_WIDTH  = 16,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_PORTS-1:0]            req_valid,
    input  logic [NUM_PORTS-1:0]            req_we,
    input  logic [NUM_PORTS*HADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  req_wdata,
    output logic [NUM_PORTS-1:0]            req_ready,
    output logic [NUM_PORTS-1:0]            rsp_valid,
    output logic                            rsp_err,
    output logic [DATA_WIDTH-1:0]           rsp_rdata,
    output logic [HADDR_WIDTH-1:0]          mc_wr_addr,
    output logic [HADDR_WIDTH-1:0]          mc_rd_addr,
    output logic [DATA_WIDTH-1:0]           mc_wr_data,
    output logic                            mc_wr_enable,
    output logic                            mc_rd_enable,
    input  logic [DATA_WIDTH-1:0]           mc_rd_data,
    input  logic                            mc_rd_ready,
    input  logic                            mc_busy
);

`ifdef SDRAM_ARB_PRIO0_EN
    localparam logic PRIO0_EN = 1'b1;
`else
    localparam logic PRIO0_EN = 1'b0;
`endif

    // Abort fires on the last permitted cycle, so ISSUE/BUSY last at most TIMEOUT_CYC cycles.
    localparam logic [ARB_TMR_W-1:0] TMO_LAST  = ARB_TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [ARB_TMR_W-1:0] TMR_ONE   = ARB_TMR_W'(1);
    localparam logic [NUM_PORTS-1:0] PORT_ONE  = NUM_PORTS'(1);
    localparam logic [DATA_WIDTH-1:0] ALL_ONES = {DATA_WIDTH{1'b1}};

    arb_state_e              state_q, state_d;
    logic [ARB_IDX_W-1:0]    win_q, win_d;
    logic [ARB_IDX_W-1:0]    last_grant_q, last_grant_d;
    logic [ARB_TMR_W-1:0]    timer_q, timer_d;
    logic                    op_we_q, op_we_d;
    logic [HADDR_WIDTH-1:0]  op_addr_q, op_addr_d;
    logic [DATA_WIDTH-1:0]   op_wdata_q, op_wdata_d;
    logic                    wr_en_q, wr_en_d;
    logic                    rd_en_q, rd_en_d;
    logic [NUM_PORTS-1:0]    req_ready_q, req_ready_d;
    logic [NUM_PORTS-1:0]    rsp_valid_q, rsp_valid_d;
    logic                    rsp_err_q, rsp_err_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;

    logic [ARB_IDX_W-1:0]    pick_idx_s;
    logic                    any_valid_s;
    logic                    sel_we_s;
    logic [HADDR_WIDTH-1:0]  sel_addr_s;
    logic [DATA_WIDTH-1:0]   sel_wdata_s;

    sdram_rr_picker #(
        .NUM_PORTS (NUM_PORTS)
    ) u_picker (
        .valid     (req_valid),
        .last_idx  (last_grant_q),
        .prio0_en  (PRIO0_EN),
        .win_idx   (pick_idx_s),
        .any_valid (any_valid_s)
    );

    // Payload mux: selects the registered winner's request fields.
    always_comb begin
        sel_we_s    = 1'b0;
        sel_addr_s  = '0;
        sel_wdata_s = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (win_q == ARB_IDX_W'(p)) begin
                sel_we_s    = req_we[p];
                sel_addr_s  = req_addr[p*HADDR_WIDTH +: HADDR_WIDTH];
                sel_wdata_s = req_wdata[p*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                sel_we_s = sel_we_s;
            end
        end
    end

    // Next-state logic; every output is computed one cycle ahead so it is registered.
    always_comb begin
        state_d      = state_q;
        win_d        = win_q;
        last_grant_d = last_grant_q;
        timer_d      = timer_q;
        op_we_d      = op_we_q;
        op_addr_d    = op_addr_q;
        op_wdata_d   = op_wdata_q;
        wr_en_d      = wr_en_q;
        rd_en_d      = rd_en_q;
        req_ready_d  = '0;
        rsp_valid_d  = '0;
        rsp_err_d    = 1'b0;
        rsp_rdata_d  = rsp_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (any_valid_s) begin
                    state_d     = ST_GRANT;
                    win_d       = pick_idx_s;
                    req_ready_d = PORT_ONE << pick_idx_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT: begin
                // req_ready is high this cycle: the payload is taken on this edge.
                last_grant_d = win_q;
                op_we_d      = sel_we_s;
                op_addr_d    = sel_addr_s;
                op_wdata_d   = sel_wdata_s;
                wr_en_d      = sel_we_s;
                rd_en_d      = ~sel_we_s;
                timer_d      = '0;
                state_d      = ST_ISSUE;
            end
            ST_ISSUE: begin
                // The controller may ignore the enable while refreshing, so hold it until busy.
                if (mc_busy) begin
                    wr_en_d = 1'b0;
                    rd_en_d = 1'b0;
                    timer_d = '0;
                    state_d = ST_BUSY;
                end else if (timer_q == TMO_LAST) begin
                    wr_en_d     = 1'b0;
                    rd_en_d     = 1'b0;
                    state_d     = ST_DONE;
                    rsp_valid_d = PORT_ONE << win_q;
                    rsp_err_d   = 1'b1;
                    if (!op_we_q) begin
                        rsp_rdata_d = ALL_ONES;
                    end else begin
                        rsp_rdata_d = rsp_rdata_q;
                    end
                end else begin
                    timer_d = timer_q + TMR_ONE;
                end
            end
            ST_BUSY: begin
                if (mc_rd_ready && !op_we_q) begin
                    rsp_rdata_d = mc_rd_data;
                end else begin
                    rsp_rdata_d = rsp_rdata_q;
                end
                if (!mc_busy) begin
                    state_d     = ST_DONE;
                    rsp_valid_d = PORT_ONE << win_q;
                end else if (timer_q == TMO_LAST) begin
                    state_d     = ST_DONE;
                    rsp_valid_d = PORT_ONE << win_q;
                    rsp_err_d   = 1'b1;
                    if (!op_we_q) begin
                        rsp_rdata_d = ALL_ONES;
                    end else begin
                        rsp_rdata_d = rsp_rdata_q;
                    end
                end else begin
                    timer_d = timer_q + TMR_ONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            win_q        <= '0;
            last_grant_q <= ARB_IDX_W'(NUM_PORTS - 1);
            timer_q      <= '0;
            op_we_q      <= 1'b0;
            op_addr_q    <= '0;
            op_wdata_q   <= '0;
            wr_en_q      <= 1'b0;
            rd_en_q      <= 1'b0;
            req_ready_q  <= '0;
            rsp_valid_q  <= '0;
            rsp_err_q    <= 1'b0;
            rsp_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            win_q        <= win_d;
            last_grant_q <= last_grant_d;
            timer_q      <= timer_d;
            op_we_q      <= op_we_d;
            op_addr_q    <= op_addr_d;
            op_wdata_q   <= op_wdata_d;
            wr_en_q      <= wr_en_d;
            rd_en_q      <= rd_en_d;
            req_ready_q  <= req_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_err_q    <= rsp_err_d;
            rsp_rdata_q  <= rsp_rdata_d;
        end
    end

    assign req_ready    = req_ready_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_err      = rsp_err_q;
    assign rsp_rdata    = rsp_rdata_q;
    assign mc_wr_addr   = op_addr_q;
    assign mc_rd_addr   = op_addr_q;
    assign mc_wr_data   = op_wdata_q;
    assign mc_wr_enable = wr_en_q;
    assign mc_rd_enable = rd_en_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_sdram_port_arbiter
// Directed bench for sdram_port_arbiter with a small SDRAM controller model.
// Expected grants and completions are queued when a request is driven and
// popped by a monitor when the DUT pulses req_ready / rsp_valid.
// Honors SDRAM_ARB_PRIO0_EN for the expected grant order.
// ----------------------------------------------------------------------------
module tb_sdram_port_arbiter;

    localparam int NP = 2;
    localparam int AW = 24;
    localparam int DW = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NP-1:0]     req_valid, req_we, req_ready, rsp_valid;
    logic [NP*AW-1:0]  req_addr;
    logic [NP*DW-1:0]  req_wdata;
    logic              rsp_err;
    logic [DW-1:0]     rsp_rdata, mc_wr_data, mc_rd_data;
    logic [AW-1:0]     mc_wr_addr, mc_rd_addr;
    logic              mc_wr_enable, mc_rd_enable, mc_rd_ready, mc_busy;

    sdram_port_arbiter #(
        .NUM_PORTS(NP), .HADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYC(255)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
        .mc_wr_addr(mc_wr_addr), .mc_rd_addr(mc_rd_addr), .mc_wr_data(mc_wr_data),
        .mc_wr_enable(mc_wr_enable), .mc_rd_enable(mc_rd_enable),
        .mc_rd_data(mc_rd_data), .mc_rd_ready(mc_rd_ready), .mc_busy(mc_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            port;
        logic          err;
        logic [DW-1:0] rdata;
    } rsp_t;

    rsp_t          rsp_q[$];
    int            grant_q[$];
    int            n_cmp = 0;
    int            n_err = 0;
    int            n_rsp = 0;
    logic [DW-1:0] exp_rdata = '0;

    // controller model knobs (written by the main sequence only)
    int            ignore_cyc  = 0;
    bit            never_busy  = 1'b0;
    bit            model_kill  = 1'b0;
    logic [DW-1:0] model_rdata = '0;

    int            en_run      = 0;
    int            en_run_last = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Controller model: optional ignored-enable window, busy 2 cycles after
    // the enable is taken, 5 busy cycles, read-data strobe as busy falls.
    initial begin
        int phase;
        int cnt;
        int ign;
        bit rd_op;
        phase = 0; cnt = 0; ign = 0; rd_op = 1'b0;
        mc_busy = 1'b0; mc_rd_ready = 1'b0; mc_rd_data = '0;
        forever begin
            @(negedge clk);
            mc_rd_ready = 1'b0;
            if (model_kill) begin
                phase = 0; ign = 0; mc_busy = 1'b0;
            end else begin
                case (phase)
                    0: if ((mc_wr_enable || mc_rd_enable) && !never_busy) begin
                        rd_op = mc_rd_enable;
                        if (ign < ignore_cyc) ign++;
                        else begin ign = 0; phase = 1; cnt = 1; end
                    end
                    1: if (cnt == 0) begin mc_busy = 1'b1; phase = 2; cnt = 4; end
                       else cnt--;
                    2: if (cnt == 0) begin
                        mc_busy = 1'b0; phase = 0;
                        // strobe on writes too: the arbiter must ignore it
                        mc_rd_ready = 1'b1; mc_rd_data = rd_op ? model_rdata : 16'h5A5A;
                    end else cnt--;
                    default: phase = 0;
                endcase
            end
        end
    end

    // Monitor: enable run length, grant scoreboard, completion scoreboard.
    initial begin
        int   g;
        rsp_t e;
        forever begin
            @(negedge clk);
            if (mc_wr_enable || mc_rd_enable) en_run++;
            else if (en_run != 0) begin en_run_last = en_run; en_run = 0; end
            if (req_ready !== '0) begin
                if (grant_q.size() == 0) check("unexpected_ready", 32'(req_ready), 32'd0);
                else begin
                    g = grant_q.pop_front();
                    check("grant", 32'(req_ready), 32'd1 << g);
                end
            end
            if (rsp_valid !== '0) begin
                n_rsp++;
                if (rsp_q.size() == 0) check("unexpected_rsp", 32'(rsp_valid), 32'd0);
                else begin
                    e = rsp_q.pop_front();
                    check("rsp_port", 32'(rsp_valid), 32'd1 << e.port);
                    check("rsp_err", 32'(rsp_err), 32'(e.err));
                    check("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
                end
            end
        end
    end

    // Queue expectations for one op and drive it until accepted.
    task automatic do_op(input int p, input bit we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [DW-1:0] rd, input bit err);
        rsp_t e;
        int   k;
        req_we[p] = we;
        req_addr[p*AW +: AW] = a;
        req_wdata[p*DW +: DW] = d;
        model_rdata = rd;
        if (!we) exp_rdata = err ? 16'hFFFF : rd;
        e.port = p; e.err = err; e.rdata = exp_rdata;
        grant_q.push_back(p);
        rsp_q.push_back(e);
        req_valid[p] = 1'b1;
        for (k = 0; k < 20 && !req_ready[p]; k++) step();
        check("accept_seen", 32'(req_ready[p]), 32'd1);
        step();
        req_valid[p] = 1'b0;
    endtask

    task automatic wait_rsp(input int target, input int budget);
        for (int k = 0; k < budget && n_rsp < target; k++) step();
        check("rsp_count", 32'(n_rsp), 32'(target));
    endtask

    initial begin
        int pend[NP];
        int tgt;
        int k;
        rst_n = 1'b0; req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        step(); step();
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        check("rst_enables", 32'({mc_wr_enable, mc_rd_enable, rsp_err}), 32'd0);
        check("rst_addr", 32'(mc_wr_addr | mc_rd_addr), 32'd0);
        check("rst_wdata", 32'(mc_wr_data), 32'd0);
        rst_n = 1'b1;
        step();

        // contention: both ports continuously valid, 4 writes each
        model_rdata = 16'h5555;
        for (int i = 0; i < 8; i++) begin
            rsp_t e;
`ifdef SDRAM_ARB_PRIO0_EN
            e.port = (i < 4) ? 0 : 1;
`else
            e.port = i % 2;
`endif
            e.err = 1'b0; e.rdata = exp_rdata;
            grant_q.push_back(e.port);
            rsp_q.push_back(e);
        end
        req_we = 2'b11;
        req_addr = {24'h000200, 24'h000100};
        req_wdata = {16'h2222, 16'h1111};
        pend[0] = 4; pend[1] = 4;
        tgt = n_rsp + 8;
        req_valid = 2'b11;
        for (k = 0; k < 400 && n_rsp < tgt; k++) begin
            step();
            for (int i = 0; i < NP; i++) begin
                if (req_ready[i] && pend[i] > 0) begin
                    pend[i]--;
                    if (pend[i] == 0) req_valid[i] = 1'b0;
                end
            end
        end
        check("rr_rsp_count", 32'(n_rsp), 32'(tgt));
        req_valid = '0;
        step();

        // single write on port 1
        tgt = n_rsp + 1;
        do_op(1, 1'b1, 24'h012345, 16'hBEEF, 16'h0000, 1'b0);
        for (k = 0; k < 20 && !mc_wr_enable; k++) step();
        check("wr_enable", 32'(mc_wr_enable), 32'd1);
        check("wr_rd_enable_low", 32'(mc_rd_enable), 32'd0);
        check("wr_addr", 32'(mc_wr_addr), 32'h012345);
        check("rd_addr_mirror", 32'(mc_rd_addr), 32'h012345);
        check("wr_data", 32'(mc_wr_data), 32'hBEEF);
        wait_rsp(tgt, 60);
        check("wr_enable_run", 32'(en_run_last), 32'd3);

        // read on port 0: completion one cycle after busy falls
        tgt = n_rsp + 1;
        do_op(0, 1'b0, 24'h000777, 16'h0000, 16'hA5A5, 1'b0);
        for (k = 0; k < 30 && !mc_busy; k++) step();
        for (k = 0; k < 30 && mc_busy; k++) step();
        step();
        check("rd_done_timing", 32'(rsp_valid), 32'd1);
        wait_rsp(tgt, 10);

        // enable ignored for 12 cycles (refresh), write keeps old rdata
        ignore_cyc = 12;
        tgt = n_rsp + 1;
        do_op(1, 1'b1, 24'h0ABCDE, 16'h1357, 16'h0000, 1'b0);
        wait_rsp(tgt, 80);
        check("refresh_enable_run", 32'(en_run_last), 32'd15);
        ignore_cyc = 0;

        // controller never goes busy: read aborts after 255 cycles
        never_busy = 1'b1;
        tgt = n_rsp + 1;
        do_op(0, 1'b0, 24'h000042, 16'h0000, 16'h1111, 1'b1);
        wait_rsp(tgt, 400);
        check("timeout_enable_run", 32'(en_run_last), 32'd255);
        never_busy = 1'b0;
        step();

        // reset while BUSY: op dropped, no completion
        req_we[0] = 1'b0; req_addr[AW-1:0] = 24'h000900; model_rdata = 16'h7777;
        grant_q.push_back(0);
        req_valid[0] = 1'b1;
        for (k = 0; k < 20 && !req_ready[0]; k++) step();
        check("rst_op_accept", 32'(req_ready[0]), 32'd1);
        step();
        req_valid[0] = 1'b0;
        for (k = 0; k < 30 && !mc_busy; k++) step();
        check("rst_op_busy", 32'(mc_busy), 32'd1);
        step();
        rst_n = 1'b0; model_kill = 1'b1;
        step();
        check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_enables", 32'({mc_wr_enable, mc_rd_enable}), 32'd0);
        check("mid_rst_rdata", 32'(rsp_rdata), 32'd0);
        check("mid_rst_addr", 32'(mc_rd_addr), 32'd0);
        exp_rdata = '0;
        step();
        rst_n = 1'b1; model_kill = 1'b0;
        step();
        tgt = n_rsp + 1;
        do_op(1, 1'b0, 24'h00F00D, 16'h0000, 16'h1234, 1'b0);
        wait_rsp(tgt, 60);
        step(); step();
        check("rsp_queue_empty", 32'(rsp_q.size()), 32'd0);
        check("grant_queue_empty", 32'(grant_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
